// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: round-robin drain controller for a bank of output FIFOs.
// A channel is granted in IDLE, then read in bursts of up to `burst` words
// into a one-word registered output stage with valid/ready handshake.
// Optional build macro DRAIN_CNT_EN adds a 16-bit wrapping drain counter.
module ofifo_drain_ctrl #(
   parameter int col   = 4,   // drained channels, 2..8
   parameter int bw    = 4,   // bits per SIMD lane
   parameter int simd  = 1,   // lanes per FIFO word
   parameter int burst = 4    // max reads per grant, 1..16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col-1:0]           fifo_empty,
   input  logic [col*simd*bw-1:0]   fifo_out,
   output logic [col-1:0]           fifo_rd,
   output logic [simd*bw-1:0]       out_data,
   output logic [2:0]               out_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     idle
`ifdef DRAIN_CNT_EN
   ,
   output logic [15:0]              drain_cnt
`endif
);

   localparam int W = simd * bw;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t       state, state_nx;
   logic [2:0]   rr_ptr, rr_ptr_nx;
   logic [2:0]   cur_ch, cur_ch_nx;
   logic [4:0]   beat_cnt, beat_cnt_nx;

   logic         load_ok;
   logic         head_empty;
   logic         do_read;
   logic         any_ready;
   logic [7:0]   empty_pad;
   logic [W-1:0] head_word;
   logic [2:0]   grant_ch;
   logic [2:0]   ch_succ;

   // The output register may be (re)loaded when it is empty or being accepted.
   assign load_ok   = !out_valid || out_ready;
   assign any_ready = ~&fifo_empty;
   assign ch_succ   = (cur_ch == 3'(col - 1)) ? 3'd0 : cur_ch + 3'd1;
   assign head_empty = empty_pad[cur_ch];

   // A read happens only inside a burst, with room downstream and data present;
   // reset masks the strobe so no FIFO pointer moves while the block is reset.
   assign do_read = !reset && (state == BURST) && load_ok && !head_empty;

   assign idle = (state == IDLE) && !out_valid;

   // Pad the empty flags to eight channels so a 3-bit channel index always
   // selects a defined bit; unused channels read as permanently empty.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves
      // it unassigned and no latch is inferred.
      empty_pad = '1;
      empty_pad[col-1:0] = fifo_empty;
   end

   // Head word of the channel currently holding the grant.
   always_comb begin
      head_word = '0;
      for (int i = 0; i < col; i++) begin
         if (cur_ch == 3'(i)) head_word = fifo_out[i*W +: W];
      end
   end

   // First non-empty channel at or after rr_ptr, wrapping modulo col. The scan
   // runs from the farthest offset down so the nearest match is written last.
   always_comb begin
      logic [3:0] sum;
      logic [2:0] cand;
      sum      = '0;
      cand     = '0;
      grant_ch = rr_ptr;
      for (int k = col - 1; k >= 0; k--) begin
         sum  = {1'b0, rr_ptr} + 4'(k);
         cand = (sum >= 4'(col)) ? 3'(sum - 4'(col)) : 3'(sum);
         if (!empty_pad[cand]) grant_ch = cand;
      end
   end

   // One-hot read strobe towards the granted FIFO.
   always_comb begin
      fifo_rd = '0;
      for (int i = 0; i < col; i++) begin
         if (do_read && (cur_ch == 3'(i))) fifo_rd[i] = 1'b1;
      end
   end

   // Next-state logic: grant in IDLE, count beats in BURST, advance the
   // round-robin pointer past the served channel on every burst exit.
   always_comb begin
      state_nx    = state;
      rr_ptr_nx   = rr_ptr;
      cur_ch_nx   = cur_ch;
      beat_cnt_nx = beat_cnt;
      unique case (state)
         IDLE: begin
            if (any_ready) begin
               cur_ch_nx   = grant_ch;
               beat_cnt_nx = '0;
               state_nx    = BURST;
            end
         end
         BURST: begin
            if (load_ok) begin
               if (!head_empty) begin
                  beat_cnt_nx = beat_cnt + 5'd1;
                  if (beat_cnt + 5'd1 == 5'(burst)) begin
                     state_nx  = IDLE;
                     rr_ptr_nx = ch_succ;
                  end
               end else begin
                  // Channel ran dry before the burst limit: end early.
                  state_nx  = IDLE;
                  rr_ptr_nx = ch_succ;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         cur_ch   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         rr_ptr   <= rr_ptr_nx;
         cur_ch   <= cur_ch_nx;
         beat_cnt <= beat_cnt_nx;
      end
   end

   // Output stage: load on a read (replacing any word accepted this cycle),
   // otherwise drop the word once downstream takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (do_read) begin
         out_valid <= 1'b1;
         out_data  <= head_word;
         out_ch    <= cur_ch;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DRAIN_CNT_EN
   // Count every read strobe; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) drain_cnt <= '0;
      else if (do_read) drain_cnt <= drain_cnt + 16'd1;
   end
`endif

   // At most one FIFO is ever strobed, and never while reset is high.
   a_rd_onehot : assert property (@(posedge clk) $onehot0(fifo_rd));
   a_rd_reset  : assert property (@(posedge clk) reset |-> (fifo_rd == '0));

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Bench for ofifo_drain_ctrl: behavioural FIFO bank, transaction model of the
// grant/burst rules, per-channel order scoreboard and directed literal traces.
module tb_ofifo_drain_ctrl;

   localparam int COL   = 4;
   localparam int BW    = 4;
   localparam int SIMD  = 1;
   localparam int BURST = 4;
   localparam int W     = SIMD * BW;

   logic               clk = 1'b0;
   logic               reset;
   logic [COL-1:0]     fifo_empty;
   logic [COL*W-1:0]   fifo_out;
   logic [COL-1:0]     fifo_rd;
   logic [W-1:0]       out_data;
   logic [2:0]         out_ch;
   logic               out_valid;
   logic               out_ready;
   logic               idle;
`ifdef DRAIN_CNT_EN
   logic [15:0]        drain_cnt;
`endif

   always #5 clk = ~clk;

   ofifo_drain_ctrl #(.col(COL), .bw(BW), .simd(SIMD), .burst(BURST)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_out   (fifo_out),
      .fifo_rd    (fifo_rd),
      .out_data   (out_data),
      .out_ch     (out_ch),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .idle       (idle)
`ifdef DRAIN_CNT_EN
      ,
      .drain_cnt  (drain_cnt)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   // Bench FIFO contents (popped by the DUT strobes) and expected delivery
   // order per channel (popped when downstream accepts a word).
   logic [W-1:0] fq[COL][$];
   logic [W-1:0] sb[COL][$];
   logic [W-1:0] acc_log[$];

   // Transaction model of the controller.
   bit           m_known = 1'b0;
   bit           m_busy, m_valid;
   int           m_ch, m_beats, m_ptr, m_out_ch;
   logic [W-1:0] m_data;

   bit             rst_drv, rdy_drv;
   logic [COL-1:0] last_rd;
   logic [W-1:0]   last_data;
   logic [2:0]     last_ch;
   logic           last_valid, last_idle;
   int             dut_reads;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int ch, input logic [W-1:0] d);
      fq[ch].push_back(d);
      sb[ch].push_back(d);
   endtask

   // One clock: drive and compare on the falling edge, then advance the
   // bench FIFOs, the scoreboard and the model across the rising edge.
   task automatic tick();
      int             exp_rd;
      logic [COL-1:0] exp_vec, emp_snap;
      logic [W-1:0]   head, junk;
      bit             rst_cur, rdy_cur, load_ok;
      int             c;
      @(negedge clk);
      reset     = rst_drv;
      out_ready = rdy_drv;
      for (int i = 0; i < COL; i++) begin
         fifo_empty[i]      = (fq[i].size() == 0);
         fifo_out[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
      end
      #1;
      rst_cur  = rst_drv;
      rdy_cur  = rdy_drv;
      emp_snap = fifo_empty;
      exp_rd   = -1;
      if (!rst_cur && m_busy && (!m_valid || rdy_cur) && !emp_snap[m_ch]) exp_rd = m_ch;
      exp_vec = '0;
      if (exp_rd >= 0) exp_vec[exp_rd] = 1'b1;
      check("fifo_rd", 32'(fifo_rd), 32'(exp_vec));
      if (m_known) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("out_data",  32'(out_data),  32'(m_data));
         check("out_ch",    32'(out_ch),    32'(m_out_ch));
         check("idle",      32'(idle),      32'(!m_busy && !m_valid));
      end
      last_rd    = fifo_rd;
      last_data  = out_data;
      last_ch    = out_ch;
      last_valid = out_valid;
      last_idle  = idle;
      head = (exp_rd >= 0) ? fq[m_ch][0] : '0;
      @(posedge clk);
      if (m_known && last_valid === 1'b1 && rdy_cur) begin
         c = int'(last_ch);
         if (c >= COL || sb[c].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_src: got word 0x%0h on ch %0d, want no word pending", last_data, c);
         end else begin
            check("accept_order", 32'(last_data), 32'(sb[c].pop_front()));
            acc_log.push_back(last_data);
         end
      end
      for (int i = 0; i < COL; i++) begin
         if (last_rd[i] === 1'b1 && fq[i].size() != 0) begin
            junk = fq[i].pop_front();
            dut_reads++;
         end
      end
      if (rst_cur) begin
         // A held word that was not accepted is discarded by reset.
         if (m_known && m_valid && !rdy_cur) junk = sb[m_out_ch].pop_front();
         m_known = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_data = '0;
         m_ch = 0; m_beats = 0; m_ptr = 0; m_out_ch = 0; dut_reads = 0;
      end else begin
         load_ok = !m_valid || rdy_cur;
         if (exp_rd >= 0) begin
            m_valid  = 1'b1;
            m_data   = head;
            m_out_ch = m_ch;
            m_beats++;
            if (m_beats == BURST) begin
               m_busy = 1'b0;
               m_ptr  = (m_ch + 1) % COL;
            end
         end else begin
            if (m_valid && rdy_cur) m_valid = 1'b0;
            if (m_busy && load_ok) begin
               m_busy = 1'b0;
               m_ptr  = (m_ch + 1) % COL;
            end else if (!m_busy) begin
               for (int k = 0; k < COL; k++) begin
                  c = (m_ptr + k) % COL;
                  if (!m_busy && !emp_snap[c]) begin
                     m_ch = c; m_beats = 0; m_busy = 1'b1;
                  end
               end
            end
         end
      end
   endtask

   // Step n cycles comparing fifo_rd to a nibble trace read left to right.
   task automatic expect_rd_seq(input string name, input logic [63:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check(name, 32'(last_rd), 32'(pat[4*(n-1-i) +: 4]));
      end
   endtask

   task automatic do_reset();
      rst_drv = 1'b1;
      tick();
      rst_drv = 1'b0;
      acc_log.delete();
   endtask

   function automatic bit all_done();
      bit d = !m_busy && !m_valid;
      for (int i = 0; i < COL; i++) d = d && (fq[i].size() == 0) && (sb[i].size() == 0);
      return d;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] e_log;
      int          pushed;
      bit          done;
      rst_drv = 1'b1; rdy_drv = 1'b1;
      reset = 1'b1; out_ready = 1'b1; fifo_empty = '1; fifo_out = '0;
      tick();
      tick();
      rst_drv = 1'b0;

      // All FIFOs empty: nothing happens for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("empty_rd",    32'(last_rd),    32'(0));
         check("empty_valid", 32'(last_valid), 32'(0));
         check("empty_idle",  32'(last_idle),  32'(1));
      end

      // Channel 0 with six words: burst of four, re-grant, then two.
      do_reset();
      for (int i = 1; i <= 6; i++) push(0, W'(i));
      expect_rd_seq("ch0_burst_trace", 64'h011110110, 9);
      check("ch0_count", 32'(acc_log.size()), 32'(6));
      for (int i = 0; i < acc_log.size(); i++) check("ch0_order", 32'(acc_log[i]), 32'(i + 1));

      // Channels 1 and 3: grant ch1, then ch3, then the pointer wraps to 0.
      do_reset();
      push(1, 4'h1); push(1, 4'h2); push(3, 4'h3); push(3, 4'h4);
      expect_rd_seq("rr_trace", 64'h022008800, 9);
      push(3, 4'h5); push(0, 4'h6);
      expect_rd_seq("rr_wrap_trace", 64'h010080, 6);

      // Channel 2 with three words and downstream stalled on cycles 3..7.
      do_reset();
      push(2, 4'hA); push(2, 4'hB); push(2, 4'hC);
      for (int i = 0; i < 10; i++) begin
         rdy_drv = !(i >= 3 && i <= 7);
         tick();
         check("stall_trace", 32'(last_rd), (i == 1 || i == 2 || i == 8) ? 32'h4 : 32'h0);
         if (i >= 3 && i <= 7) check("stall_hold", 32'(last_data), 32'hB);
      end
      check("stall_count", 32'(acc_log.size()), 32'(3));
      rdy_drv = 1'b1;

      // Reset in the second read cycle of a burst on channel 1.
      do_reset();
      push(1, 4'h5); push(1, 4'h6); push(1, 4'h7);
      tick();
      tick();
      check("pre_reset_rd", 32'(last_rd), 32'h2);
      push(0, 4'h9); push(3, 4'h3);
      rst_drv = 1'b1;
      tick();
      check("rd_in_reset", 32'(last_rd), 32'h0);
      rst_drv = 1'b0;
      tick();
      check("valid_after_reset", 32'(last_valid), 32'(0));
      check("rd_after_reset",    32'(last_rd),    32'(0));
      expect_rd_seq("post_reset_trace", 64'h100220080, 9);
      check("reset_log_count", 32'(acc_log.size()), 32'(5));
      e_log = 20'h59673;
      if (acc_log.size() == 5)
         for (int i = 0; i < 5; i++) check("reset_log", 32'(acc_log[i]), 32'(e_log[4*(4-i) +: 4]));

      // Randomised traffic: 70 words over all channels with random back-pressure.
      do_reset();
      pushed = 0;
      while (pushed < 70) begin
         if ($urandom_range(1, 0) == 1) begin
            push(int'($urandom_range(COL - 1, 0)), W'(pushed + 1));
            pushed++;
         end
         rdy_drv = ($urandom_range(3, 0) != 0);
         tick();
      end
      for (int t = 0; t < 3000 && !all_done(); t++) begin
         rdy_drv = ($urandom_range(3, 0) != 0);
         tick();
      end
      done = all_done();
      check("drain_complete", 32'(done), 32'(1));
      check("strobe_total", 32'(dut_reads), 32'(70));
      rdy_drv = 1'b1;
      tick();
      @(negedge clk);
`ifdef DRAIN_CNT_EN
      check("drain_cnt", 32'(drain_cnt), 32'(70));
`endif
      check("final_idle", 32'(idle), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
